// File: rtl/control_debouncer.sv
// control_debouncer
// Conditions a raw, bouncy push-button/switch level for the downstream 4-bit
// counter. The input is synchronised through SYNC_STAGES flops and filtered by
// a four-state debounce FSM. A transition is accepted only after
// DEBOUNCE_CYCLES consecutive synchronised samples at the new level. The block
// outputs a clean level plus one-cycle rise/fall pulses. All outputs are
// registered.
//
// Optional build macro: CONTROL_DEBOUNCER_TOGGLE_EN
//   defined   -> control toggles on each accepted press and ignores accepted
//                releases. rise_pulse/fall_pulse still report the raw
//                debounced edges.
//   undefined -> control follows the debounced button level.
module control_debouncer #(
    parameter int  SYNC_STAGES     = 2,
    parameter int  DEBOUNCE_CYCLES = 16,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic control,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    typedef enum logic [1:0] {
        STABLE_LOW    = 2'd0,
        DEBOUNCE_HIGH = 2'd1,
        STABLE_HIGH   = 2'd2,
        DEBOUNCE_LOW  = 2'd3
    } state_t;

    // The counter holds the number of consecutive candidate samples seen so
    // far. Acceptance happens on the sample that would make it DEBOUNCE_CYCLES,
    // so the counter itself never exceeds DEBOUNCE_CYCLES-1 and never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   control_q, control_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;

    // Synchroniser chain: bit 0 captures the raw pin, and the last bit is the
    // only value the FSM ever looks at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce FSM state, stability counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STABLE_LOW;
            cnt_q     <= '0;
            control_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            control_q <= control_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic. A single sample back at the stable level aborts
    // qualification with no partial credit. Pulses default low, so each one
    // lasts exactly one cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        control_d = control_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;

        case (state_q)
            STABLE_LOW: begin
                if (s) begin
                    state_d = DEBOUNCE_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end

            DEBOUNCE_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
`ifdef CONTROL_DEBOUNCER_TOGGLE_EN
                    control_d = ~control_q;
`else
                    control_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            STABLE_HIGH: begin
                if (!s) begin
                    state_d = DEBOUNCE_LOW;
                    cnt_d   = CNT_ONE;
                end
            end

            DEBOUNCE_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
`ifndef CONTROL_DEBOUNCER_TOGGLE_EN
                    control_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase

        // busy is registered alongside the state, so it is high exactly while
        // the FSM sits in a qualifying state.
        busy_d = (state_d == DEBOUNCE_HIGH) || (state_d == DEBOUNCE_LOW);
    end

    assign control    = control_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_control_debouncer.sv
// Testbench for control_debouncer: directed scenarios plus randomised bouncing,
// checked against a sample-history reference model through a pulse scoreboard.
`timescale 1ns/1ps
module tb_control_debouncer;

    localparam int SS  = 2;
    localparam int DC  = 16;
    localparam int LAT = SS + DC;   // rising edges, inclusive, from capture to output
`ifdef CONTROL_DEBOUNCER_TOGGLE_EN
    localparam bit TOGGLE = 1'b1;
`else
    localparam bit TOGGLE = 1'b0;
`endif

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic btn_in = 1'b0;
    logic control, rise_pulse, fall_pulse, busy;

    int total = 0;
    int bad   = 0;

    control_debouncer #(
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .control   (control),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int edge_no;
        bit is_rise;
        bit ctrl;
    } exp_t;

    exp_t exp_q[$];
    bit   dly_q[$];    // raw level travelling through the synchroniser
    bit   hist_q[$];   // most recent DC samples seen by the filter
    bit   level_m;     // accepted button level
    bit   ctrl_m;      // expected control output
    bit   busy_m;
    int   edge_cnt = 0;
    bit   mon_en   = 1'b0;
    bit   m_smp;
    int   m_run;
    exp_t m_e;

    task automatic model_reset();
        dly_q.delete();
        for (int i = 0; i < SS; i++) dly_q.push_back(1'b0);
        hist_q.delete();
        exp_q.delete();
        level_m = 1'b0;
        ctrl_m  = 1'b0;
        busy_m  = 1'b0;
    endtask

    // The filter sees the raw level SS edges late. A transition is accepted when
    // the last DC samples all differ from the accepted level.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            edge_cnt++;
            m_smp = dly_q.pop_front();
            dly_q.push_back(btn_in);
            hist_q.push_back(m_smp);
            if (hist_q.size() > DC) hist_q.delete(0);
            m_run = 0;
            for (int i = hist_q.size() - 1; i >= 0; i--) begin
                if (hist_q[i] != level_m) m_run++;
                else break;
            end
            if (m_run == DC) begin
                level_m = ~level_m;
                if (level_m) ctrl_m = TOGGLE ? ~ctrl_m : 1'b1;
                else if (!TOGGLE) ctrl_m = 1'b0;
                m_e.edge_no = edge_cnt;
                m_e.is_rise = level_m;
                m_e.ctrl    = ctrl_m;
                exp_q.push_back(m_e);
                busy_m = 1'b0;
            end else begin
                busy_m = (m_run > 0);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("control_level", control, ctrl_m);
            chk("busy_level", busy, busy_m);
            if (rise_pulse || fall_pulse) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {rise_pulse, fall_pulse}, 2'b00);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_edge", edge_cnt, mon_e.edge_no);
                    chk("pulse_kind", {rise_pulse, fall_pulse}, mon_e.is_rise ? 2'b10 : 2'b01);
                    chk("pulse_control", control, mon_e.ctrl);
                end
            end else if (exp_q.size() != 0 && exp_q[0].edge_no <= edge_cnt) begin
                mon_e = exp_q.pop_front();
                chk("missing_pulse", {rise_pulse, fall_pulse}, mon_e.is_rise ? 2'b10 : 2'b01);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Called right after btn_in changes. The next edge is the capturing edge,
    // so the pulse must appear after edge LAT-1 counted from zero.
    task automatic measure(input string tag, input bit rise, input bit exp_ctrl);
        int  busy_n = 0;
        bit  seen   = 1'b0;
        for (int k = 0; k < LAT + 20 && !seen; k++) begin
            @(posedge clk);
            #2;
            if (busy) busy_n++;
            if (rise ? rise_pulse : fall_pulse) begin
                seen = 1'b1;
                chk({tag, "_latency"}, k + 1, LAT);
                chk({tag, "_busy_cycles"}, busy_n, DC - 1);
                chk({tag, "_control"}, control, exp_ctrl);
            end
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
        @(posedge clk);
        #2;
        chk({tag, "_pulse_width"}, {rise_pulse, fall_pulse}, 2'b00);
    endtask

    initial begin
        model_reset();
        #6;
        mon_en = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // idle after reset
        for (int i = 0; i < 20; i++) begin
            hold(1);
            chk("reset_idle", {control, rise_pulse, fall_pulse, busy}, 4'b0000);
        end

        // clean press and release
        btn_in = 1'b1;
        measure("press", 1'b1, 1'b1);
        hold(10);
        btn_in = 1'b0;
        measure("release", 1'b0, TOGGLE ? 1'b1 : 1'b0);
        hold(10);

        // bounce: never stable long enough
        btn_in = 1'b1; hold(6);
        btn_in = 1'b0; hold(1);
        btn_in = 1'b1; hold(5);
        btn_in = 1'b0; hold(30);
        chk("bounce_control", control, TOGGLE ? 1'b1 : 1'b0);

        // second press/release pair
        btn_in = 1'b1;
        measure("press2", 1'b1, TOGGLE ? 1'b0 : 1'b1);
        hold(10);
        btn_in = 1'b0;
        measure("release2", 1'b0, 1'b0);
        hold(10);

        // random bouncing segments
        for (int i = 0; i < 40; i++) begin
            btn_in = 1'($urandom_range(0, 1));
            hold($urandom_range(1, 24));
        end
        btn_in = 1'b0;
        hold(40);

        // reset while qualifying a press
        btn_in = 1'b1;
        hold(12);
        chk("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_state", {control, busy}, 2'b00);
        hold(2);
        rst_n = 1'b1;
        measure("press_after_reset", 1'b1, 1'b1);
        hold(10);

        // reset while qualifying a release from control=1
        btn_in = 1'b0;
        hold(12);
        chk("pre_reset_control", control, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_release", {control, busy}, 2'b00);
        hold(2);
        rst_n = 1'b1;
        hold(25);

        hold(5);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
